axistream_pkt_source: RTL and testbench

//   AXI-Stream transmitter (master end of axistream_if). Accepts a packet command
//   (byte length + seed), emits one packet of incrementing-byte payload on the stream,

---
 rtl/axistream_pkt_source.sv | 131 +++++++++++++
 tb/tb_axistream_pkt_source.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axistream_pkt_source.sv
// AXI-Stream packet source: takes a (length, seed) command and emits one packet
// of incrementing bytes, with TLAST/TKEEP on the final beat and full TREADY backpressure.
module axistream_pkt_source #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [7:0]          cmd_seed,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                busy,
  output logic                pkt_done
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [7:0]          byte_q, byte_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [BYTES-1:0]    tkeep_q, tkeep_d;
  logic                tlast_q, tlast_d;
  logic [LEN_W-1:0]    nxt_rem;
  logic [7:0]          nxt_byte;

  // rem is the byte count still owed including the beat being built
  function automatic logic [BYTES-1:0] beat_keep(input logic [LEN_W-1:0] rem);
    logic [BYTES-1:0] keep;
    keep = '0;
    for (int j = 0; j < BYTES; j++) keep[j] = (rem > LEN_W'(j));
    return keep;
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [7:0] base,
                                                  input logic [LEN_W-1:0] rem);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int j = 0; j < BYTES; j++)
      if (rem > LEN_W'(j)) data[8*j +: 8] = base + 8'(j);
    return data;
  endfunction

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    byte_d   = byte_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    nxt_rem  = rem_q - BYTES_L;
    nxt_byte = byte_q + 8'(BYTES);
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rem_d  = cmd_len;
          byte_d = cmd_seed;
          if (cmd_len == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SEND;
            tvalid_d = 1'b1;
            tdata_d  = beat_data(cmd_seed, cmd_len);
            tkeep_d  = beat_keep(cmd_len);
            tlast_d  = (cmd_len <= BYTES_L);
          end
        end
      end
      SEND: begin
        if (tvalid_q && m_tready) begin
          if (tlast_q) begin
            state_d  = DONE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
          end else begin
            // Next beat is staged here so it appears the cycle after the transfer
            rem_d   = nxt_rem;
            byte_d  = nxt_byte;
            tdata_d = beat_data(nxt_byte, nxt_rem);
            tkeep_d = beat_keep(nxt_rem);
            tlast_d = (nxt_rem <= BYTES_L);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      byte_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      byte_q   <= byte_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == SEND);
  assign pkt_done  = (state_q == DONE);
  assign m_tvalid  = tvalid_q;
  assign m_tdata   = tdata_q;
  assign m_tkeep   = tkeep_q;
  assign m_tlast   = tlast_q;

endmodule

// File: tb/tb_axistream_pkt_source.sv
// Scoreboard bench for axistream_pkt_source: commands push expected beats,
// the negedge monitor pops and compares every stream transfer.
module tb_axistream_pkt_source;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int BYTES  = DATA_W / 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [7:0]        cmd_seed = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DATA_W-1:0] m_tdata;
  logic [BYTES-1:0]  m_tkeep;
  logic              m_tlast;
  logic              busy;
  logic              pkt_done;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_beat_cyc = -1;
  int    done_count = 0;
  int    exp_done = 0;
  bit    rand_ready = 1'b0;

  axistream_pkt_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .busy(busy), .pkt_done(pkt_done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference packet model: byte i = seed + i, keep set for bytes below len
  task automatic pushExpected(input int len, input logic [7:0] seed);
    int nbeats;
    beat_t b;
    nbeats = (len + BYTES - 1) / BYTES;
    for (int k = 0; k < nbeats; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < BYTES; j++) begin
        int i;
        i = k * BYTES + j;
        if (i < len) begin
          b.keep[j]       = 1'b1;
          b.data[8*j +: 8] = seed + 8'(i);
        end
      end
      b.last = (k == nbeats - 1);
      sb.push_back(b);
    end
  endtask

  // Monitor: inputs change #1 after posedge, so negedge values are what the next edge sees
  initial forever begin
    @(negedge clk);
    if (!rst && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 64'(m_tdata), 64'hDEAD);
      end else begin
        beat_t e;
        e = sb.pop_front();
        checkOutput("tdata", 64'(m_tdata), 64'(e.data));
        checkOutput("tkeep", 64'(m_tkeep), 64'(e.keep));
        checkOutput("tlast", 64'(m_tlast), 64'(e.last));
        if (m_tlast) last_beat_cyc = cyc;
      end
    end
    if (!rst && pkt_done) begin
      done_count++;
      if (last_beat_cyc >= 0) checkOutput("done_latency", 64'(cyc - last_beat_cyc), 64'd1);
      last_beat_cyc = -1;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  end

  // Offers one command, returns #1 after the accepting edge
  task automatic applyStimulus(input int len, input logic [7:0] seed);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_seed  = seed;
    pushExpected(len, seed);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = '1;
    cmd_seed  = 8'hAA;
    checkOutput("first_valid", 64'(m_tvalid), 64'(len != 0));
    checkOutput("busy_after_accept", 64'(busy), 64'(len != 0));
    checkOutput("pkt_done_after_accept", 64'(pkt_done), 64'(len == 0));
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) break;
      n++;
    end
    if (n >= budget) checkOutput("idle_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_tvalid",    64'(m_tvalid),  64'd0);
    checkOutput("rst_tlast",     64'(m_tlast),   64'd0);
    checkOutput("rst_tdata",     64'(m_tdata),   64'd0);
    checkOutput("rst_tkeep",     64'(m_tkeep),   64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_pkt_done",  64'(pkt_done),  64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8, 8'h10);  exp_done++; waitIdle(50);
    applyStimulus(5, 8'h10);  exp_done++; waitIdle(50);

    // Hold TREADY low for three cycles while beat 2 of a 3-beat packet is presented
    applyStimulus(12, 8'h00); exp_done++;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_tvalid", 64'(m_tvalid), 64'd1);
      if (sb.size() > 0) checkOutput("stall_tdata", 64'(m_tdata), 64'(sb[0].data));
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    waitIdle(50);

    applyStimulus(0, 8'h55);  exp_done++;
    checkOutput("zero_len_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("zero_len_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("zero_len_done_off",  64'(pkt_done),  64'd0);

    applyStimulus(4, 8'hFE);  exp_done++; waitIdle(50);

    rand_ready = 1'b1;
    applyStimulus(37, 8'hFF); exp_done++; waitIdle(400);
    applyStimulus(3, 8'h80);  exp_done++; waitIdle(400);
    applyStimulus(13, 8'h7E); exp_done++; waitIdle(400);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;

    applyStimulus(65535, 8'hC3); exp_done++; waitIdle(20000);
    checkOutput("done_count_mid", 64'(done_count), 64'(exp_done));

    // Abort a 4-beat packet with a one-cycle reset while beat 2 is valid
    applyStimulus(16, 8'h20);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_beat_cyc = -1;
    checkOutput("abort_tvalid",    64'(m_tvalid),  64'd0);
    checkOutput("abort_busy",      64'(busy),      64'd0);
    checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort_pkt_done",  64'(pkt_done),  64'd0);
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 64'(done_count), 64'(exp_done));

    applyStimulus(4, 8'h30);  exp_done++; waitIdle(50);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_count_final", 64'(done_count), 64'(exp_done));
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
